fb_write_arbiter: RTL and testbench

- Owns the single write port of the 640x480x8 framebuffer RAM.
- Sequences a full-screen clear at power-up and whenever a clear is requested.
- Outside a clear, shares the port between two pixel-write requesters using round-robin: port A is the cursor brush, port B is a secondary drawer (fill or UI overlay).
- Sits between the cursor/drawing blocks and ram_2port, and drives the memory's we, write_addr and data_in.

---
 rtl/fb_pkg.sv | 29 ++
 rtl/rr_arbiter2.sv | 40 ++++
 rtl/fb_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_fb_write_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer write-port arbiter.
package fb_pkg;

    // Top-level sequencing: power-up idle, full-screen clear, normal pixel traffic.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } fb_state_e;

    // Identity of the requester that last owned the write port.
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    localparam int FB_H_RES  = 640;
    localparam int FB_V_RES  = 480;
    localparam int FB_ADDR_W = 20;
    localparam int FB_DATA_W = 8;

    // Number of addressable pixels for a given screen geometry.
    function automatic int fb_pixels(input int h_res, input int v_res);
        return h_res * v_res;
    endfunction

    localparam int FB_PIXELS = fb_pixels(FB_H_RES, FB_V_RES);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with an enable; grant is one-hot {B, A}.
module rr_arbiter2
    import fb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       req_a_i,
    input  logic       req_b_i,
    output logic [1:0] grant_o
);

    grant_e last_grant_q;

    // Grant the lone requester, or the one not served last when both ask.
    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            if (req_a_i && req_b_i) begin
                grant_o = (last_grant_q == GRANT_B) ? 2'b01 : 2'b10;
            end else if (req_a_i) begin
                grant_o = 2'b01;
            end else if (req_b_i) begin
                grant_o = 2'b10;
            end
        end
    end

    // Remember who was served so a contended cycle alternates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= GRANT_B;
        end else if (grant_o[0]) begin
            last_grant_q <= GRANT_A;
        end else if (grant_o[1]) begin
            last_grant_q <= GRANT_B;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Owner of the framebuffer RAM write port: full-screen clear sequencing
// plus round-robin sharing between the cursor brush (A) and a drawer (B).
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int H_RES  = FB_H_RES,
    parameter int V_RES  = FB_V_RES,
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_color,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              we,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] data_in,
    output logic              busy_clearing,
    output logic              initialized,
    output logic              drop
);

    localparam int                PIXELS    = fb_pixels(H_RES, V_RES);
    localparam logic [ADDR_W:0]   PIXELS_W  = (ADDR_W + 1)'(PIXELS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    fb_state_e         state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] color_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              busy_q;
    logic              init_q;
    logic              drop_q;

    logic              arb_en_d;
    logic [1:0]        grant_d;
    logic              start_clear_d;
    logic              hs_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_data_d;
    logic              in_range_d;

    // A clear request pre-empts the requesters in the same cycle.
    rr_arbiter2 u_arb (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .en_i    (arb_en_d),
        .req_a_i (a_valid),
        .req_b_i (b_valid),
        .grant_o (grant_d)
    );

    // Handshake decode and range check for the granted requester.
    always_comb begin
        arb_en_d      = (state_q == RUN) && !clear_req;
        start_clear_d = (state_q == IDLE) || clear_req;
        hs_d          = |grant_d;
        sel_addr_d    = grant_d[1] ? b_addr : a_addr;
        sel_data_d    = grant_d[1] ? b_data : a_data;
        in_range_d    = ({1'b0, sel_addr_d} < PIXELS_W);
    end

    // Main sequencer; every RAM-facing output is registered here.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            color_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            init_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            if (start_clear_d) begin
                // Start (or restart) the sweep: pixel 0 is written next cycle.
                state_q <= CLEAR;
                cnt_q   <= '0;
                color_q <= clear_color;
                we_q    <= 1'b1;
                addr_q  <= '0;
                data_q  <= clear_color;
                busy_q  <= 1'b1;
                init_q  <= 1'b0;
            end else begin
                case (state_q)
                    CLEAR: begin
                        if (cnt_q == LAST_ADDR) begin
                            state_q <= RUN;
                            we_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            init_q  <= 1'b1;
                        end else begin
                            cnt_q  <= cnt_q + 1'b1;
                            we_q   <= 1'b1;
                            addr_q <= cnt_q + 1'b1;
                            data_q <= color_q;
                        end
                    end
                    RUN: begin
                        if (hs_d) begin
                            // Out-of-range pixels are accepted but never reach the RAM.
                            we_q   <= in_range_d;
                            drop_q <= !in_range_d;
                            if (in_range_d) begin
                                addr_q <= sel_addr_d;
                                data_q <= sel_data_d;
                            end
                        end else begin
                            we_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign a_ready       = grant_d[0];
    assign b_ready       = grant_d[1];
    assign we            = we_q;
    assign write_addr    = addr_q;
    assign data_in       = data_q;
    assign busy_clearing = busy_q;
    assign initialized   = init_q;
    assign drop          = drop_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter on an 8x4 screen (32 pixels).
module tb_fb_write_arbiter;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;
    localparam int NPIX   = 32;

    logic              CLOCK_50 = 1'b0;
    logic              reset;
    logic              clear_req;
    logic [DATA_W-1:0] clear_color;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              we;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] data_in;
    logic              busy_clearing;
    logic              initialized;
    logic              drop;

    int checks = 0;
    int errors = 0;

    fb_write_arbiter #(.H_RES(8), .V_RES(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .clear_req     (clear_req),
        .clear_color   (clear_color),
        .a_valid       (a_valid),
        .a_addr        (a_addr),
        .a_data        (a_data),
        .a_ready       (a_ready),
        .b_valid       (b_valid),
        .b_addr        (b_addr),
        .b_data        (b_data),
        .b_ready       (b_ready),
        .we            (we),
        .write_addr    (write_addr),
        .data_in       (data_in),
        .busy_clearing (busy_clearing),
        .initialized   (initialized),
        .drop          (drop)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic              av;
        logic [ADDR_W-1:0] aa;
        logic [DATA_W-1:0] ad;
        logic              bv;
        logic [ADDR_W-1:0] ba;
        logic [DATA_W-1:0] bd;
        logic              cr;
        logic [DATA_W-1:0] cc;
        logic              ear;
        logic              ebr;
        logic              ewe;
        logic [ADDR_W-1:0] eaddr;
        logic [DATA_W-1:0] edata;
        logic              edrop;
        logic              ebusy;
        logic              einit;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input int av, input int aa, input int ad,
                                input int bv, input int ba, input int bd,
                                input int cr, input int cc,
                                input int ear, input int ebr, input int ewe,
                                input int ea, input int ed, input int edr,
                                input int ebu, input int ein);
        vec_t v;
        v.av    = av[0];
        v.aa    = ADDR_W'(aa);
        v.ad    = DATA_W'(ad);
        v.bv    = bv[0];
        v.ba    = ADDR_W'(ba);
        v.bd    = DATA_W'(bd);
        v.cr    = cr[0];
        v.cc    = DATA_W'(cc);
        v.ear   = ear[0];
        v.ebr   = ebr[0];
        v.ewe   = ewe[0];
        v.eaddr = ADDR_W'(ea);
        v.edata = DATA_W'(ed);
        v.edrop = edr[0];
        v.ebusy = ebu[0];
        v.einit = ein[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " we"},   32'(we), 0);
        chk({tag, " addr"}, 32'(write_addr), 0);
        chk({tag, " data"}, 32'(data_in), 0);
        chk({tag, " rdy"},  32'({a_ready, b_ready}), 0);
        chk({tag, " busy"}, 32'(busy_clearing), 0);
        chk({tag, " init"}, 32'(initialized), 0);
        chk({tag, " drop"}, 32'(drop), 0);
    endtask

    // Walk clear cycles first..last, checking one sweep write per cycle.
    task automatic clear_cycles(input logic [7:0] color, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(posedge CLOCK_50);
            #1;
            clear_req = 1'b0;
            #4;
            chk("clr busy", 32'(busy_clearing), 1);
            chk("clr init", 32'(initialized), 0);
            chk("clr we", 32'(we), 1);
            chk("clr addr", 32'(write_addr), 32'(i));
            chk("clr data", 32'(data_in), 32'(color));
            chk("clr rdy", 32'({a_ready, b_ready}), 0);
        end
    endtask

    // First cycle after the sweep: back in RUN with initialized set.
    task automatic done_check(input logic exp_a_ready);
        @(posedge CLOCK_50);
        #1;
        clear_req = 1'b0;
        #4;
        chk("done busy", 32'(busy_clearing), 0);
        chk("done init", 32'(initialized), 1);
        chk("done we", 32'(we), 0);
        chk("done a_ready", 32'(a_ready), 32'(exp_a_ready));
        chk("done b_ready", 32'(b_ready), 0);
    endtask

    initial begin
        reset       = 1'b1;
        clear_req   = 1'b0;
        clear_color = 8'h78;
        a_valid     = 1'b0;
        a_addr      = '0;
        a_data      = '0;
        b_valid     = 1'b0;
        b_addr      = '0;
        b_data      = '0;

        //               av aa  ad    bv ba  bd    cr cc     ar br we addr data  dr bu in
        tbl[0]  = mk(0, 0, 8'h00, 0, 0,  8'h00, 0, 8'h00, 0, 0, 0, 31, 8'h78, 0, 0, 1);
        tbl[1]  = mk(1, 3, 8'h11, 0, 0,  8'h00, 0, 8'h00, 1, 0, 0, 31, 8'h78, 0, 0, 1);
        tbl[2]  = mk(1, 4, 8'h11, 0, 0,  8'h00, 0, 8'h00, 1, 0, 1, 3,  8'h11, 0, 0, 1);
        tbl[3]  = mk(1, 5, 8'h11, 0, 0,  8'h00, 0, 8'h00, 1, 0, 1, 4,  8'h11, 0, 0, 1);
        tbl[4]  = mk(1, 6, 8'h11, 0, 0,  8'h00, 0, 8'h00, 1, 0, 1, 5,  8'h11, 0, 0, 1);
        tbl[5]  = mk(1, 7, 8'h22, 1, 10, 8'h33, 0, 8'h00, 0, 1, 1, 6,  8'h11, 0, 0, 1);
        tbl[6]  = mk(1, 7, 8'h22, 1, 10, 8'h33, 0, 8'h00, 1, 0, 1, 10, 8'h33, 0, 0, 1);
        tbl[7]  = mk(1, 7, 8'h22, 1, 10, 8'h33, 0, 8'h00, 0, 1, 1, 7,  8'h22, 0, 0, 1);
        tbl[8]  = mk(1, 7, 8'h22, 1, 10, 8'h33, 0, 8'h00, 1, 0, 1, 10, 8'h33, 0, 0, 1);
        tbl[9]  = mk(1, 7, 8'h22, 1, 10, 8'h33, 0, 8'h00, 0, 1, 1, 7,  8'h22, 0, 0, 1);
        tbl[10] = mk(1, 7, 8'h22, 1, 10, 8'h33, 0, 8'h00, 1, 0, 1, 10, 8'h33, 0, 0, 1);
        tbl[11] = mk(0, 0, 8'h00, 1, 32, 8'h44, 0, 8'h00, 0, 1, 1, 7,  8'h22, 0, 0, 1);
        tbl[12] = mk(0, 0, 8'h00, 0, 0,  8'h00, 0, 8'h00, 0, 0, 0, 7,  8'h22, 1, 0, 1);
        tbl[13] = mk(0, 0, 8'h00, 0, 0,  8'h00, 0, 8'h00, 0, 0, 0, 7,  8'h22, 0, 0, 1);
        tbl[14] = mk(0, 0, 8'h00, 1, 31, 8'h55, 0, 8'h00, 0, 1, 0, 7,  8'h22, 0, 0, 1);
        tbl[15] = mk(1, 1, 8'h66, 0, 0,  8'h00, 1, 8'h9A, 0, 0, 1, 31, 8'h55, 0, 0, 1);
        tbl[16] = mk(1, 1, 8'h66, 0, 0,  8'h00, 0, 8'h00, 0, 0, 1, 0,  8'h9A, 0, 1, 0);

        // Reset held: everything idle.
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;

        // Power-up sweep with colour 0x78.
        clear_cycles(8'h78, 0, NPIX - 1);
        done_check(1'b0);

        // Table-driven RUN traffic, drop, and clear pre-emption.
        for (int k = 0; k < 17; k++) begin
            @(posedge CLOCK_50);
            #1;
            a_valid     = tbl[k].av;
            a_addr      = tbl[k].aa;
            a_data      = tbl[k].ad;
            b_valid     = tbl[k].bv;
            b_addr      = tbl[k].ba;
            b_data      = tbl[k].bd;
            clear_req   = tbl[k].cr;
            clear_color = tbl[k].cc;
            #4;
            chk($sformatf("v%0d a_ready", k), 32'(a_ready), 32'(tbl[k].ear));
            chk($sformatf("v%0d b_ready", k), 32'(b_ready), 32'(tbl[k].ebr));
            chk($sformatf("v%0d we", k), 32'(we), 32'(tbl[k].ewe));
            chk($sformatf("v%0d addr", k), 32'(write_addr), 32'(tbl[k].eaddr));
            chk($sformatf("v%0d data", k), 32'(data_in), 32'(tbl[k].edata));
            chk($sformatf("v%0d drop", k), 32'(drop), 32'(tbl[k].edrop));
            chk($sformatf("v%0d busy", k), 32'(busy_clearing), 32'(tbl[k].ebusy));
            chk($sformatf("v%0d init", k), 32'(initialized), 32'(tbl[k].einit));
        end

        // A keeps waiting through the rest of the 0x9A sweep, then gets the port.
        clear_cycles(8'h9A, 1, NPIX - 1);
        done_check(1'b1);
        @(posedge CLOCK_50);
        #1;
        a_valid = 1'b0;
        #4;
        chk("post-clear A we", 32'(we), 1);
        chk("post-clear A addr", 32'(write_addr), 1);
        chk("post-clear A data", 32'(data_in), 32'h66);

        // Clear restarted mid-sweep picks up the new colour from address 0.
        @(posedge CLOCK_50);
        #1;
        clear_req   = 1'b1;
        clear_color = 8'h5A;
        #4;
        chk("clr req rdy", 32'({a_ready, b_ready}), 0);
        clear_cycles(8'h5A, 0, 3);
        @(posedge CLOCK_50);
        #1;
        clear_req   = 1'b1;
        clear_color = 8'hC3;
        #4;
        chk("restart cyc addr", 32'(write_addr), 4);
        chk("restart cyc data", 32'(data_in), 32'h5A);
        clear_cycles(8'hC3, 0, NPIX - 1);
        done_check(1'b0);

        // Asynchronous reset in the middle of a sweep.
        @(posedge CLOCK_50);
        #1;
        clear_req   = 1'b1;
        clear_color = 8'h0F;
        #4;
        clear_cycles(8'h0F, 0, 19);
        reset = 1'b1;
        #1;
        chk_all_zero("async rst");
        repeat (2) @(posedge CLOCK_50);
        #1;
        reset       = 1'b0;
        clear_color = 8'hE1;
        clear_cycles(8'hE1, 0, NPIX - 1);
        done_check(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
